// File: rtl/pbit_array_updater.sv
// pbit_array_updater
//
// Sequential p-bit array that performs Gibbs-style single-bit updates of the
// candidate factor X. Bits are updated one at a time, and each update is
// preceded by a latch cycle. The external energy calculator therefore always
// sees the current X before its probability code is captured.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   start        one-cycle run request, sampled only when idle
//   stop         abort request, honoured in any non-idle state
//   n_sweeps     sweeps per run; 0 runs until stop
//   N_digit      bit length of the current N; active X width is (N_digit+1)/2
//   X_init       starting value of X
//   pbit_in_0..7 probability planes; bit j of plane k is bit k of the code for X[j+1]
//   X            current candidate factor (registered)
//   busy         high whenever the updater is not idle
//   sweep_done   one-cycle pulse at the end of each sweep
//   done         one-cycle pulse when n_sweeps sweeps have completed
module pbit_array_updater #(
  parameter int unsigned max_N_digit = 64,
  parameter logic [31:0] LFSR_SEED   = 32'hACE1_2468
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       stop,
  input  logic [15:0]                n_sweeps,
  input  logic [6:0]                 N_digit,
  input  logic [max_N_digit/2-1:0]   X_init,
  input  logic [max_N_digit/2-2:0]   pbit_in_0,
  input  logic [max_N_digit/2-2:0]   pbit_in_1,
  input  logic [max_N_digit/2-2:0]   pbit_in_2,
  input  logic [max_N_digit/2-2:0]   pbit_in_3,
  input  logic [max_N_digit/2-2:0]   pbit_in_4,
  input  logic [max_N_digit/2-2:0]   pbit_in_5,
  input  logic [max_N_digit/2-2:0]   pbit_in_6,
  input  logic [max_N_digit/2-2:0]   pbit_in_7,
  output logic [max_N_digit/2-1:0]   X,
  output logic                       busy,
  output logic                       sweep_done,
  output logic                       done
);

  localparam int XW = int'(max_N_digit / 2);
  localparam int IW = $clog2(XW + 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StLatch  = 2'd1;
  localparam logic [1:0] StUpdate = 2'd2;
  localparam logic [1:0] StEnd    = 2'd3;

  // Galois taps for x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LfsrTaps = 32'h8020_0003;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [15:0]   sweep_cnt_q, sweep_cnt_d;
  logic [31:0]   lfsr_q, lfsr_d;
  logic [7:0]    code_q, code_d;
  logic [XW-1:0] x_q, x_d;
  logic          sweep_done_q, sweep_done_d;
  logic          done_q, done_d;

  logic [XW-2:0] planes [8];
  logic [7:0]    w_raw;
  logic [IW-1:0] w_act;
  logic          w_ge2;
  logic          last_idx;
  logic [XW-1:0] x_mask;
  logic [7:0]    code_sel;
  logic          upd_bit;
  logic [XW-1:0] x_upd;
  logic [31:0]   lfsr_step;
  logic [15:0]   sweep_cnt_inc;
  logic          run_complete;

  assign planes[0] = pbit_in_0;
  assign planes[1] = pbit_in_1;
  assign planes[2] = pbit_in_2;
  assign planes[3] = pbit_in_3;
  assign planes[4] = pbit_in_4;
  assign planes[5] = pbit_in_5;
  assign planes[6] = pbit_in_6;
  assign planes[7] = pbit_in_7;

  // Active width, clamped to the physical width of X for oversized N_digit.
  assign w_raw = ({1'b0, N_digit} + 8'd1) >> 1;

  always_comb begin
    if (w_raw > 8'(XW)) begin
      w_act = IW'(XW);
    end else begin
      w_act = w_raw[IW-1:0];
    end
  end

  assign w_ge2    = (w_act >= IW'(2));
  assign last_idx = (idx_q == w_act - IW'(1));

  always_comb begin
    x_mask = '0;
    for (int i = 0; i < XW; i++) begin
      x_mask[i] = (i < int'(w_act));
    end
  end

  // Gather the 8-bit threshold for X[idx] from bit idx-1 of every plane.
  always_comb begin
    code_sel = '0;
    for (int j = 0; j < XW - 1; j++) begin
      if (idx_q == IW'(j + 1)) begin
        for (int k = 0; k < 8; k++) begin
          code_sel[k] = planes[k][j];
        end
      end
    end
  end

  assign upd_bit = (lfsr_q[7:0] < code_q);

  always_comb begin
    x_upd = x_q;
    for (int i = 1; i < XW; i++) begin
      if (idx_q == IW'(i)) begin
        x_upd[i] = upd_bit;
      end
    end
  end

  assign lfsr_step     = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LfsrTaps : 32'h0);
  assign sweep_cnt_inc = sweep_cnt_q + 16'd1;
  assign run_complete  = (n_sweeps != 16'd0) && (sweep_cnt_inc == n_sweeps);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    sweep_cnt_d  = sweep_cnt_q;
    lfsr_d       = lfsr_q;
    code_d       = code_q;
    x_d          = x_q;
    sweep_done_d = 1'b0;
    done_d       = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          x_d         = (X_init & x_mask) | XW'(1);
          idx_d       = IW'(1);
          sweep_cnt_d = '0;
          state_d     = w_ge2 ? StLatch : StEnd;
        end
      end

      StLatch: begin
        if (stop) begin
          state_d = StIdle;
        end else begin
          code_d  = code_sel;
          state_d = StUpdate;
        end
      end

      StUpdate: begin
        if (stop) begin
          state_d = StIdle;
        end else begin
          x_d    = x_upd;
          lfsr_d = lfsr_step;
          if (last_idx) begin
            state_d = StEnd;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = StLatch;
          end
        end
      end

      StEnd: begin
        // An abort landing on the sweep boundary suppresses both pulses.
        if (stop) begin
          state_d = StIdle;
        end else begin
          sweep_done_d = 1'b1;
          sweep_cnt_d  = sweep_cnt_inc;
          idx_d        = IW'(1);
          if (run_complete) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = w_ge2 ? StLatch : StEnd;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      idx_q        <= IW'(1);
      sweep_cnt_q  <= '0;
      lfsr_q       <= LFSR_SEED;
      code_q       <= '0;
      x_q          <= XW'(1);
      sweep_done_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      sweep_cnt_q  <= sweep_cnt_d;
      lfsr_q       <= lfsr_d;
      code_q       <= code_d;
      x_q          <= x_d;
      sweep_done_q <= sweep_done_d;
      done_q       <= done_d;
    end
  end

  assign X          = x_q;
  assign busy       = (state_q != StIdle);
  assign sweep_done = sweep_done_q;
  assign done       = done_q;

endmodule

// File: doc/pbit_array_updater.md
Name: pbit_array_updater

Overview:
- Sequential p-bit array that consumes the eight per-bit probability planes from the energy calculator and performs Gibbs-style single-bit updates of the candidate factor X.
- One bit is updated at a time, with a settle cycle per bit, so the combinational energy path always sees the current X.
- Runs a programmable number of sweeps and reports each completed sweep to the downstream decision/sieve logic.

Parameters:
- max_N_digit, 7'd64, maximum bit width of N; X is max_N_digit/2 bits wide.
- LFSR_SEED, 32'hACE1_2468, reset and initial value of the internal LFSR; must be nonzero.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a run; sampled only in IDLE
- stop  input  1  abort request; honoured in any non-IDLE state
- n_sweeps  input  16  sweeps per run; 0 = run until stop
- N_digit  input  7  bit length of the current N
- X_init  input  max_N_digit/2  starting value of X
- pbit_in_0 .. pbit_in_7  input  max_N_digit/2-1 each  probability planes; bit j of each plane belongs to X[j+1]
- X  output  max_N_digit/2  current candidate factor (registered)
- busy  output  1  high in every state except IDLE
- sweep_done  output  1  one-cycle pulse at the end of every sweep; X is stable in that cycle
- done  output  1  one-cycle pulse when n_sweeps sweeps have completed

Behaviour:
- Reset values:
  - X = 1; busy, sweep_done, done = 0.
  - State = IDLE; idx = 1; sweep_cnt = 0; lfsr = LFSR_SEED; code_r = 0.
- Active width: W = (N_digit+1)/2, integer division.
  - Active update bits are X[1]..X[W-1].
  - X[0] is always 1.
  - X[W] and above are always 0.
- Threshold code for bit i: code = {pbit_in_7[i-1], pbit_in_6[i-1], ..., pbit_in_0[i-1]}, treated as an unsigned 8-bit threshold.
- Random byte: rnd = lfsr[7:0].
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1.
  - On each step, shift right; if the old bit 0 was 1, XOR the new value with 32'h8020_0003.
  - Steps only in UPDATE.
- FSM states: IDLE, LATCH, UPDATE, END.
  - IDLE, start=1:
    - X <= (X_init masked to bits below W) | 1.
    - idx <= 1; sweep_cnt <= 0.
    - If W >= 2, go to LATCH; otherwise go to END.
    - start in any other state is ignored.
  - LATCH: code_r <= code for idx; go to UPDATE. This gives the energy path one full cycle to settle on the current X.
  - UPDATE:
    - X[idx] <= (rnd < code_r); step the LFSR.
    - If idx == W-1, go to END; otherwise idx <= idx+1 and go to LATCH.
  - END:
    - sweep_done <= 1; sweep_cnt <= sweep_cnt+1; idx <= 1.
    - If n_sweeps != 0 and sweep_cnt+1 == n_sweeps: done <= 1, go to IDLE.
    - Otherwise go to LATCH, or stay in END when W < 2.
- Timing:
  - Cost per sweep is 2*(W-1)+1 cycles.
  - With the start edge numbered 0, done is high in the cycle after edge 1 + n_sweeps*(2*(W-1)+1) - 1.
- Code boundaries:
  - code = 0x00 always writes 0.
  - code = 0xFF writes 1 unless rnd = 0xFF.
- Width: sweep_cnt is 16 bits. With n_sweeps = 0, sweep_cnt wraps silently and done never pulses.
- stop in LATCH, UPDATE or END:
  - Next state is IDLE; X holds its current value.
  - No sweep_done or done pulse is generated.
  - If stop and END coincide, stop wins and no pulses are generated.
- rst mid-run: all registers return to their reset values on the next edge, including lfsr = LFSR_SEED.
- N_digit and n_sweeps are sampled every cycle. They must be held constant while busy; changing them mid-run is undefined.

Test Plan:
- Reset then idle: rst for 2 cycles -> X = 1, busy = 0, lfsr = 32'hACE1_2468; 10 idle cycles with start = 0 -> no change.
- All-zero planes: N_digit = 8, X_init = 8'h0F, n_sweeps = 1, start -> X = 1 after sweep; sweep_done and done both high in cycle 7 after start; busy high for cycles 1..7.
- All-one planes (code 0xFF): N_digit = 8, X_init = 1, n_sweeps = 2 -> X = 4'hF unless a reference-model rnd equals 0xFF; exactly two sweep_done pulses, 7 cycles apart; done coincides with the second.
- Width masking: N_digit = 5 (W = 3), X_init = 32'hFFFF_FFFF, code 0xFF -> X[31:3] = 0 after start, only bits 1..2 updated, 5 cycles per sweep; N_digit = 2 (W = 1) -> END-only sweeps, X = 1.
- Free-run and stop: n_sweeps = 0 -> sweep_done repeats and done never fires; stop asserted in an UPDATE cycle -> IDLE next cycle, no sweep_done, X frozen.
- Start-while-busy and mid-run reset: start pulses during a run are ignored (same X trajectory as a golden LFSR model); rst in LATCH -> X = 1, lfsr = seed, and a rerun reproduces the first run bit-exactly.
